// File: rtl/bram_uart_dumper.sv
// Streams a range of 32-bit BRAM words out to a byte-wide UART transmitter, MSB first.
// Handshake per byte: trigger, wait for busy to rise, wait for busy to fall.
module bram_uart_dumper #(
   parameter int ADDR_WIDTH   = 15,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic [ADDR_WIDTH-1:0] base_addr_in,
   input  logic [ADDR_WIDTH:0]   word_count_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [31:0]           data_in,
   output logic [7:0]            byte_out,
   output logic                  trigger_out,
   input  logic                  tx_busy_in,
   output logic                  busy_out,
   output logic                  done_out
);
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, ACK, DRAIN, FINISH} state_t;

   state_t            state;
   logic [31:0]       word;
   logic [1:0]        idx;
   logic [ADDR_WIDTH:0] count;
   logic [LAT_W-1:0]  lat;
   logic [7:0]        sel;

   always_comb begin
      sel = word[31:24];
      case (idx)
         2'd0: sel = word[31:24];
         2'd1: sel = word[23:16];
         2'd2: sel = word[15:8];
         2'd3: sel = word[7:0];
         default: sel = word[31:24];
      endcase
   end

   // State is a register, so busy_out is glitch-free without its own flop.
   assign busy_out = (state != IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= IDLE;
         addr_out    <= '0;
         byte_out    <= '0;
         trigger_out <= 1'b0;
         done_out    <= 1'b0;
         word        <= '0;
         idx         <= '0;
         count       <= '0;
         lat         <= '0;
      end else begin
         trigger_out <= 1'b0;
         done_out    <= 1'b0;
         if (abort_in && state != IDLE) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (start_in) begin
                  addr_out <= base_addr_in;
                  count    <= word_count_in;
                  lat      <= '0;
                  state    <= (word_count_in == '0) ? FINISH : FETCH;
               end
               FETCH: begin
                  if (lat == LAT_LAST) state <= LATCH;
                  else lat <= lat + 1'b1;
               end
               LATCH: begin
                  word  <= data_in;
                  idx   <= '0;
                  state <= SEND;
               end
               SEND: if (!tx_busy_in) begin
                  byte_out    <= sel;
                  trigger_out <= 1'b1;
                  state       <= ACK;
               end
               // Wait for the transmitter to acknowledge before looking for idle again.
               ACK: if (tx_busy_in) state <= DRAIN;
               DRAIN: if (!tx_busy_in) begin
                  if (idx != 2'd3) begin
                     idx   <= idx + 1'b1;
                     state <= SEND;
                  end else begin
                     count <= count - 1'b1;
                     if (count == LAST_WORD) begin
                        state <= FINISH;
                     end else begin
                        addr_out <= addr_out + 1'b1;
                        lat      <= '0;
                        state    <= FETCH;
                     end
                  end
               end
               FINISH: begin
                  done_out <= 1'b1;
                  state    <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/bram_uart_dumper.md
BRAM_UART_DUMPER -- requirements
Module: bram_uart_dumper

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, sets the BRAM word address width.
REQ-002 Parameter READ_LATENCY, default 2, sets the BRAM read latency in cycles from addr_out to valid data_in.
REQ-003 Port clk_in, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_in, input, 1: synchronous, active-high reset.
REQ-005 Port start_in, input, 1: single-cycle request to begin a dump.
REQ-006 Port abort_in, input, 1: level; cancels a dump in progress.
REQ-007 Port base_addr_in, input, ADDR_WIDTH: first word address; latched on accepted start.
REQ-008 Port word_count_in, input, ADDR_WIDTH+1: number of words to dump; latched on accepted start.
REQ-009 Port addr_out, output, ADDR_WIDTH: BRAM port-A read address.
REQ-010 Port data_in, input, 32: BRAM port-A read data.
REQ-011 Port byte_out, output, 8: byte to the UART transmitter data_byte_in.
REQ-012 Port trigger_out, output, 1: single-cycle send strobe to the UART transmitter trigger_in.
REQ-013 Port tx_busy_in, input, 1: UART transmitter busy_out.
REQ-014 Port busy_out, output, 1: high whenever the block is not in IDLE.
REQ-015 Port done_out, output, 1: single-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, LATCH, SEND, ACK, DRAIN and FINISH.
REQ-017 IDLE: start_in=1 latches base/count, sets addr_out=base_addr_in and goes to FETCH; if the latched count is 0, go to FINISH instead.
REQ-018 start_in outside IDLE SHALL be ignored.
REQ-019 FETCH: hold addr_out for exactly READ_LATENCY cycles, then go to LATCH.
REQ-020 LATCH: capture data_in into a 32-bit word register, clear the byte index to 0, then go to SEND.
REQ-021 SEND: with tx_busy_in=0, drive byte_out = word[31-8*idx -: 8] (MSB first) and pulse trigger_out for 1 cycle, then go to ACK; with tx_busy_in=1, wait in SEND.
REQ-022 ACK: wait until tx_busy_in=1, then go to DRAIN; trigger_out SHALL stay 0 in ACK.
REQ-023 DRAIN: wait until tx_busy_in=0; then, for idx<3, increment idx and go to SEND.
REQ-024 DRAIN exit with idx=3: decrement the remaining count; if it reaches 0, go to FINISH; otherwise increment addr_out (modulo 2^ADDR_WIDTH, wrapping) and go to FETCH.
REQ-025 FINISH: pulse done_out for 1 cycle, then return to IDLE.
REQ-026 byte_out SHALL hold its value from the trigger cycle until the next trigger.
REQ-027 At most one trigger_out pulse SHALL occur per byte; trigger_out SHALL never be asserted while tx_busy_in=1.
REQ-028 abort_in=1 in any non-IDLE state SHALL move the FSM to IDLE on the next cycle with no done_out; trigger_out is 0 in that cycle.
REQ-029 abort_in SHALL take priority over start_in and over every state transition.
REQ-030 A byte already triggered when abort_in asserts completes inside the transmitter; this block does not wait for it.
REQ-031 The block SHALL emit exactly 4*word_count_in bytes per completed dump, in address order.

Reset
REQ-032 rst_in=1 SHALL force state IDLE and drive addr_out=0, byte_out=0, trigger_out=0, busy_out=0, done_out=0, and clear the word, index and count registers.
REQ-033 rst_in SHALL take priority over abort_in and start_in; reset during a dump discards it without done_out.

Verification
REQ-034 The bench SHALL cover a basic dump: BRAM[5]=0xDEADBEEF, base=5, count=1, transmitter model busy 1 cycle after trigger for 10 cycles -> bytes DE, AD, BE, EF; 4 triggers; one done_out; busy_out low afterward.
REQ-035 The bench SHALL cover multiple words with wrap: ADDR_WIDTH=4, base=15, count=2, BRAM[15]=0x01020304, BRAM[0]=0x05060708 -> bytes 01..08 in order; addr_out sequence 15, 0.
REQ-036 The bench SHALL cover a zero count: start with count=0 -> done_out 2 cycles after start, no trigger_out.
REQ-037 The bench SHALL cover backpressure: tx_busy_in held at 1 for 50 cycles at start -> no trigger until it falls, then the normal sequence.
REQ-038 The bench SHALL cover abort: abort_in asserted after the 2nd byte's trigger, count=3 -> IDLE next cycle, no further triggers, no done_out; a new start then dumps correctly.
REQ-039 The bench SHALL cover reset mid-dump: rst_in during DRAIN -> all outputs 0 the next cycle; a start_in asserted together with rst_in is ignored.
